// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU pipeline definitions used by the hazard controller and the bench.
package hazard_ctrl_pkg;

  typedef enum logic {
    MemIdle,
    MemWait
  } mem_state_e;

  // Writeback select value that marks a load in EX.
  localparam logic [1:0] WdSelLoad = 2'b01;

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-memory wait stalls with timeout, branch flush,
// load-use bubble insertion and stall/flush statistics.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    rf_ra0_id,
  input  logic [4:0]    rf_ra1_id,
  input  logic          rf_re0_id,
  input  logic          rf_re1_id,
  input  logic [4:0]    rf_wa_ex,
  input  logic          rf_we_ex,
  input  logic [1:0]    rf_wd_sel_ex,
  input  logic          npc_sel_ex,
  input  logic          mem_access_mem,
  output logic          dmem_req,
  input  logic          dmem_ack,
  output logic          stall_pc,
  output logic          stall_if_id,
  output logic          stall_id_ex,
  output logic          stall_ex_mem,
  output logic          flush_if_id,
  output logic          flush_id_ex,
  output logic          flush_mem_wb,
  output logic          mem_err,
  output logic [CW-1:0] stall_cycles,
  output logic [CW-1:0] flush_events
);

  localparam int unsigned WCW = ($clog2(TIMEOUT + 1) > 9) ? $clog2(TIMEOUT + 1) : 9;

  mem_state_e     r_state, w_state_d;
  logic           r_dmem_req, w_dmem_req_d;
  logic           r_mem_err, w_mem_err_d;
  logic [WCW-1:0] r_wait_cnt, w_wait_cnt_d, w_wait_inc;
  logic [CW-1:0]  r_stall_cycles, r_flush_events;
  logic           w_mem_stall, w_timeout, w_load_use, w_branch, w_lu_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= MemIdle;
      r_dmem_req     <= 1'b0;
      r_mem_err      <= 1'b0;
      r_wait_cnt     <= '0;
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      r_state    <= w_state_d;
      r_dmem_req <= w_dmem_req_d;
      r_mem_err  <= w_mem_err_d;
      r_wait_cnt <= w_wait_cnt_d;
      if (stall_pc) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (flush_if_id || flush_id_ex) r_flush_events <= r_flush_events + 1'b1;
    end
  end

  // The access is abandoned on the edge where the counter would reach TIMEOUT.
  always_comb begin
    w_wait_inc = r_wait_cnt + 1'b1;
    w_timeout  = (r_state == MemWait) && !dmem_ack && (w_wait_inc == WCW'(TIMEOUT));
  end

  always_comb begin
    w_state_d    = r_state;
    w_dmem_req_d = r_dmem_req;
    w_mem_err_d  = r_mem_err;
    w_wait_cnt_d = r_wait_cnt;
    w_mem_stall  = 1'b0;
    case (r_state)
      MemIdle: begin
        if (mem_access_mem) begin
          w_state_d    = MemWait;
          w_dmem_req_d = 1'b1;
          w_wait_cnt_d = '0;
          w_mem_stall  = 1'b1;
        end
      end
      MemWait: begin
        if (dmem_ack) begin
          w_state_d    = MemIdle;
          w_dmem_req_d = 1'b0;
        end else if (w_timeout) begin
          w_state_d    = MemIdle;
          w_dmem_req_d = 1'b0;
          w_mem_err_d  = 1'b1;
        end else begin
          w_wait_cnt_d = w_wait_inc;
          w_mem_stall  = 1'b1;
        end
      end
      default: w_state_d = MemIdle;
    endcase
  end

  always_comb begin
    w_load_use = rf_we_ex && (rf_wd_sel_ex == WdSelLoad) && (rf_wa_ex != 5'd0) &&
                 ((rf_re0_id && (rf_ra0_id == rf_wa_ex)) ||
                  (rf_re1_id && (rf_ra1_id == rf_wa_ex)));
    // Memory stall outranks branch, which outranks load-use; all quiet under reset.
    w_branch   = !rst && !w_mem_stall && npc_sel_ex;
    w_lu_stall = !rst && !w_mem_stall && !npc_sel_ex && w_load_use;

    stall_pc     = (!rst && w_mem_stall) || w_lu_stall;
    stall_if_id  = (!rst && w_mem_stall) || w_lu_stall;
    stall_id_ex  = !rst && w_mem_stall;
    stall_ex_mem = !rst && w_mem_stall;
    flush_mem_wb = !rst && w_mem_stall;
    flush_if_id  = w_branch;
    flush_id_ex  = w_branch || w_lu_stall;
  end

  assign dmem_req     = r_dmem_req;
  assign mem_err      = r_mem_err;
  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (TIMEOUT shortened to 4).
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rf_ra0_id, rf_ra1_id, rf_wa_ex;
  logic          rf_re0_id, rf_re1_id, rf_we_ex;
  logic [1:0]    rf_wd_sel_ex;
  logic          npc_sel_ex, mem_access_mem, dmem_ack;
  logic          dmem_req, mem_err;
  logic          stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic          flush_if_id, flush_id_ex, flush_mem_wb;
  logic [CW-1:0] stall_cycles, flush_events;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(.TIMEOUT(4), .CW(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .rf_ra0_id      (rf_ra0_id),
    .rf_ra1_id      (rf_ra1_id),
    .rf_re0_id      (rf_re0_id),
    .rf_re1_id      (rf_re1_id),
    .rf_wa_ex       (rf_wa_ex),
    .rf_we_ex       (rf_we_ex),
    .rf_wd_sel_ex   (rf_wd_sel_ex),
    .npc_sel_ex     (npc_sel_ex),
    .mem_access_mem (mem_access_mem),
    .dmem_req       (dmem_req),
    .dmem_ack       (dmem_ack),
    .stall_pc       (stall_pc),
    .stall_if_id    (stall_if_id),
    .stall_id_ex    (stall_id_ex),
    .stall_ex_mem   (stall_ex_mem),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .flush_mem_wb   (flush_mem_wb),
    .mem_err        (mem_err),
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    rf_ra0_id = 5'd0; rf_ra1_id = 5'd0; rf_wa_ex = 5'd0;
    rf_re0_id = 1'b0; rf_re1_id = 1'b0; rf_we_ex = 1'b0;
    rf_wd_sel_ex = 2'b00; npc_sel_ex = 1'b0; mem_access_mem = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    rf_we_ex = 1'b1; rf_wd_sel_ex = 2'b01; rf_wa_ex = rd;
    rf_ra0_id = rd; rf_re0_id = 1'b1;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    npc_sel_ex = 1'b1; mem_access_mem = 1'b1;
    set_load_use(5'd5);
    #2;
    n_checks++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL rst_stall_pc got %b want 0", stall_pc); end
    n_checks++; if (flush_if_id !== 1'b0) begin n_fail++; $display("FAIL rst_flush_if_id got %b want 0", flush_if_id); end
    n_checks++; if (flush_id_ex !== 1'b0) begin n_fail++; $display("FAIL rst_flush_id_ex got %b want 0", flush_id_ex); end
    n_checks++; if (flush_mem_wb !== 1'b0) begin n_fail++; $display("FAIL rst_flush_mem_wb got %b want 0", flush_mem_wb); end
    tick();
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_dmem_req got %b want 0", dmem_req); end
    n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL rst_mem_err got %b want 0", mem_err); end
    n_checks++; if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL rst_stall_cycles got %0d want 0", stall_cycles); end
    n_checks++; if (flush_events !== 16'd0) begin n_fail++; $display("FAIL rst_flush_events got %0d want 0", flush_events); end
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_load_use;
    tick();
    set_load_use(5'd5);
    #1;
    n_checks++; if (stall_pc !== 1'b1) begin n_fail++; $display("FAIL lu_stall_pc got %b want 1", stall_pc); end
    n_checks++; if (stall_if_id !== 1'b1) begin n_fail++; $display("FAIL lu_stall_if_id got %b want 1", stall_if_id); end
    n_checks++; if (flush_id_ex !== 1'b1) begin n_fail++; $display("FAIL lu_flush_id_ex got %b want 1", flush_id_ex); end
    n_checks++; if (stall_id_ex !== 1'b0) begin n_fail++; $display("FAIL lu_stall_id_ex got %b want 0", stall_id_ex); end
    n_checks++; if (flush_if_id !== 1'b0) begin n_fail++; $display("FAIL lu_flush_if_id got %b want 0", flush_if_id); end
    tick();
    clear_inputs();
    #1;
    n_checks++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL lu_after_stall_pc got %b want 0", stall_pc); end
    n_checks++; if (stall_cycles !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cycles got %0d want 1", stall_cycles); end
    n_checks++; if (flush_events !== 16'd1) begin n_fail++; $display("FAIL lu_flush_events got %0d want 1", flush_events); end
  endtask

  task automatic test_x0;
    tick();
    set_load_use(5'd0);
    #1;
    n_checks++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL x0_stall_pc got %b want 0", stall_pc); end
    n_checks++; if (flush_id_ex !== 1'b0) begin n_fail++; $display("FAIL x0_flush_id_ex got %b want 0", flush_id_ex); end
    // rs2 match through re1 only; rs1 disabled
    tick();
    clear_inputs();
    rf_we_ex = 1'b1; rf_wd_sel_ex = 2'b01; rf_wa_ex = 5'd7;
    rf_ra0_id = 5'd7; rf_re0_id = 1'b0; rf_ra1_id = 5'd7; rf_re1_id = 1'b1;
    #1;
    n_checks++; if (stall_pc !== 1'b1) begin n_fail++; $display("FAIL rs2_stall_pc got %b want 1", stall_pc); end
    tick();
    rf_re1_id = 1'b0;
    #1;
    n_checks++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL re_off_stall_pc got %b want 0", stall_pc); end
    rf_re1_id = 1'b1; rf_wd_sel_ex = 2'b00;
    #1;
    n_checks++; if (flush_id_ex !== 1'b0) begin n_fail++; $display("FAIL non_load_flush got %b want 0", flush_id_ex); end
    tick();
    clear_inputs();
    #1;
    n_checks++; if (stall_cycles !== 16'd2) begin n_fail++; $display("FAIL x0_stall_cycles got %0d want 2", stall_cycles); end
  endtask

  task automatic test_branch_vs_load_use;
    do_reset();
    tick();
    set_load_use(5'd5);
    npc_sel_ex = 1'b1;
    #1;
    n_checks++; if (flush_if_id !== 1'b1) begin n_fail++; $display("FAIL br_flush_if_id got %b want 1", flush_if_id); end
    n_checks++; if (flush_id_ex !== 1'b1) begin n_fail++; $display("FAIL br_flush_id_ex got %b want 1", flush_id_ex); end
    n_checks++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL br_stall_pc got %b want 0", stall_pc); end
    n_checks++; if (stall_if_id !== 1'b0) begin n_fail++; $display("FAIL br_stall_if_id got %b want 0", stall_if_id); end
    tick();
    clear_inputs();
    #1;
    n_checks++; if (flush_events !== 16'd1) begin n_fail++; $display("FAIL br_flush_events got %0d want 1", flush_events); end
    n_checks++; if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL br_stall_cycles got %0d want 0", stall_cycles); end
  endtask

  task automatic test_mem_wait;
    int req_high = 0;
    tick();
    mem_access_mem = 1'b1;
    #1;
    n_checks++; if (stall_ex_mem !== 1'b1) begin n_fail++; $display("FAIL mw_detect_stall_ex_mem got %b want 1", stall_ex_mem); end
    n_checks++; if (flush_mem_wb !== 1'b1) begin n_fail++; $display("FAIL mw_detect_flush_mem_wb got %b want 1", flush_mem_wb); end
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL mw_detect_dmem_req got %b want 0", dmem_req); end
    tick();
    for (int i = 1; i <= 4; i++) begin
      dmem_ack = (i == 4);
      if (i == 2) begin
        set_load_use(5'd5);
        npc_sel_ex = 1'b1;
      end else begin
        rf_we_ex = 1'b0; npc_sel_ex = 1'b0;
      end
      #1;
      if (dmem_req === 1'b1 && i < 4) req_high++;
      n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL mw_w%0d_dmem_req got %b want 1", i, dmem_req); end
      n_checks++; if (stall_pc !== (i < 4)) begin n_fail++; $display("FAIL mw_w%0d_stall_pc got %b want %b", i, stall_pc, i < 4); end
      n_checks++; if (stall_id_ex !== (i < 4)) begin n_fail++; $display("FAIL mw_w%0d_stall_id_ex got %b want %b", i, stall_id_ex, i < 4); end
      n_checks++; if (flush_mem_wb !== (i < 4)) begin n_fail++; $display("FAIL mw_w%0d_flush_mem_wb got %b want %b", i, flush_mem_wb, i < 4); end
      if (i == 2) begin
        n_checks++; if (flush_if_id !== 1'b0) begin n_fail++; $display("FAIL mw_suppress_flush_if_id got %b want 0", flush_if_id); end
        n_checks++; if (flush_id_ex !== 1'b0) begin n_fail++; $display("FAIL mw_suppress_flush_id_ex got %b want 0", flush_id_ex); end
      end
      tick();
    end
    clear_inputs();
    #1;
    n_checks++; if (req_high !== 3) begin n_fail++; $display("FAIL mw_req_cycles got %0d want 3", req_high); end
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL mw_done_dmem_req got %b want 0", dmem_req); end
    n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL mw_mem_err got %b want 0", mem_err); end
    n_checks++; if (stall_cycles !== 16'd4) begin n_fail++; $display("FAIL mw_stall_cycles got %0d want 4", stall_cycles); end
    n_checks++; if (flush_events !== 16'd1) begin n_fail++; $display("FAIL mw_flush_events got %0d want 1", flush_events); end
  endtask

  task automatic test_timeout;
    tick();
    mem_access_mem = 1'b1;
    #1;
    n_checks++; if (stall_pc !== 1'b1) begin n_fail++; $display("FAIL to_detect_stall_pc got %b want 1", stall_pc); end
    tick();
    for (int i = 1; i <= 4; i++) begin
      mem_access_mem = (i == 2);  // stray pulse in WAIT must not restart the access
      #1;
      n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL to_w%0d_dmem_req got %b want 1", i, dmem_req); end
      n_checks++; if (stall_pc !== (i < 4)) begin n_fail++; $display("FAIL to_w%0d_stall_pc got %b want %b", i, stall_pc, i < 4); end
      n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL to_w%0d_mem_err got %b want 0", i, mem_err); end
      tick();
    end
    #1;
    n_checks++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL to_mem_err got %b want 1", mem_err); end
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL to_dmem_req got %b want 0", dmem_req); end
    n_checks++; if (dut.r_state !== MemIdle) begin n_fail++; $display("FAIL to_state got %0d want %0d", dut.r_state, MemIdle); end
    n_checks++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL to_stall_pc got %b want 0", stall_pc); end
    n_checks++; if (stall_cycles !== 16'd8) begin n_fail++; $display("FAIL to_stall_cycles got %0d want 8", stall_cycles); end
    tick();
    tick();
    n_checks++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky_mem_err got %b want 1", mem_err); end
  endtask

  task automatic test_reset_in_wait;
    mem_access_mem = 1'b1;
    tick();
    mem_access_mem = 1'b0;
    tick();
    #2;
    n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL riw_pre_dmem_req got %b want 1", dmem_req); end
    rst = 1'b1;
    #1;
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL riw_dmem_req got %b want 0", dmem_req); end
    n_checks++; if (dut.r_state !== MemIdle) begin n_fail++; $display("FAIL riw_state got %0d want %0d", dut.r_state, MemIdle); end
    n_checks++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL riw_stall_pc got %b want 0", stall_pc); end
    n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL riw_mem_err got %b want 0", mem_err); end
    n_checks++; if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL riw_stall_cycles got %0d want 0", stall_cycles); end
    n_checks++; if (flush_events !== 16'd0) begin n_fail++; $display("FAIL riw_flush_events got %0d want 0", flush_events); end
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL riw_after_dmem_req got %b want 0", dmem_req); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_x0();
    test_branch_vs_load_use();
    test_mem_wait();
    test_timeout();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles before a data-memory access is abandoned.
REQ-002 SHALL have parameter CW, default 32, meaning the width of the statistics counters.
REQ-003 SHALL have ports clk (input, 1, clock) and rst (input, 1, reset), with one clock and asynchronous active-high reset.
REQ-004 SHALL have rf_ra0_id and rf_ra1_id (input, 5 each, ID source register addresses) and rf_re0_id and rf_re1_id (input, 1 each, ID source read-enables).
REQ-005 SHALL have rf_wa_ex (input, 5, EX destination), rf_we_ex (input, 1, EX write-enable) and rf_wd_sel_ex (input, 2, EX writeback select, where 2'b01 means load).
REQ-006 SHALL have npc_sel_ex (input, 1), which is high when the EX branch or jump is taken.
REQ-007 SHALL have mem_access_mem (input, 1), which is high when the MEM stage holds a load or store.
REQ-008 SHALL have dmem_req (output, 1), the registered request to data memory, and dmem_ack (input, 1), the one-cycle completion pulse.
REQ-009 SHALL have stall_pc, stall_if_id, stall_id_ex and stall_ex_mem (outputs, 1 each; each holds its register).
REQ-010 SHALL have flush_if_id, flush_id_ex and flush_mem_wb (outputs, 1 each; each inserts a bubble).
REQ-011 SHALL have mem_err (output, 1, sticky timeout flag), stall_cycles (output, CW, stall-cycle count) and flush_events (output, CW, flush-event count).

Function
REQ-012 SHALL implement a memory FSM with two states: IDLE and WAIT.
REQ-013 In IDLE with mem_access_mem=1, the FSM SHALL go to WAIT and set dmem_req=1 on that edge.
REQ-014 In WAIT, dmem_req SHALL stay 1, and stall_pc, stall_if_id, stall_id_ex, stall_ex_mem and flush_mem_wb SHALL be 1.
REQ-015 During the IDLE cycle that detects the access, the same stall set SHALL be asserted combinationally.
REQ-016 In WAIT with dmem_ack=1, all stall and flush_mem_wb outputs SHALL drop that cycle, so the instruction advances on the edge, and the FSM SHALL return to IDLE with dmem_req=0.
REQ-017 A 9-bit or wider wait counter SHALL clear on entry to WAIT and increment on each WAIT cycle without ack.
REQ-018 When the wait counter reaches TIMEOUT, the block SHALL set mem_err=1, return to IDLE, clear dmem_req, and release the stalls that cycle.
REQ-019 mem_err SHALL clear only on reset.
REQ-020 Load-use SHALL be detected when rf_we_ex=1, rf_wd_sel_ex=2'b01, rf_wa_ex!=0, and (rf_re0_id with rf_ra0_id==rf_wa_ex) or (rf_re1_id with rf_ra1_id==rf_wa_ex).
REQ-021 On load-use with no memory stall, the block SHALL assert stall_pc, stall_if_id and flush_id_ex for exactly that cycle (a one-bubble latency); register x0 never triggers it.
REQ-022 On npc_sel_ex=1 with no memory stall, the block SHALL assert flush_if_id and flush_id_ex.
REQ-023 Priority SHALL be memory stall > branch flush > load-use.
REQ-024 During a memory stall, branch and load-use outputs SHALL be suppressed.
REQ-025 When branch and load-use are simultaneous, the branch SHALL win and stall_pc SHALL stay 0.
REQ-026 stall_cycles SHALL increment on every cycle in which stall_pc=1.
REQ-027 flush_events SHALL increment on every cycle in which flush_if_id or flush_id_ex is 1.
REQ-028 Both counters SHALL wrap modulo 2^CW.
REQ-029 An mem_access_mem pulse arriving while in WAIT SHALL NOT start a second request.

Reset
REQ-030 On rst=1, asynchronously, the block SHALL enter IDLE and clear dmem_req, mem_err, the wait counter, stall_cycles and flush_events.
REQ-031 While reset is asserted, all stall and flush outputs SHALL be 0.
REQ-032 Reset asserted in WAIT SHALL abandon the access and drop dmem_req immediately.

Structure
REQ-033 The FSM state encoding and the 2'b01 load select constant SHALL live in the shared CPU package.
REQ-034 The block SHALL be a single module with no sub-modules; its stall and flush outputs drive the existing segment registers.

Verification
REQ-035 The bench SHALL check load-use: EX load to x5 with ID rs1=x5 re0=1 -> one cycle of stall_pc=stall_if_id=flush_id_ex=1, then stall_cycles=1.
REQ-036 The bench SHALL check the x0 case: EX load to x0 with ID rs1=x0 -> no stall and no flush.
REQ-037 The bench SHALL check a memory wait: mem_access_mem=1 with ack 3 cycles after dmem_req -> 4 stall cycles, dmem_req high for 3 cycles, and release on the ack cycle.
REQ-038 The bench SHALL check branch against load-use: npc_sel_ex=1 together with load-use -> flush_if_id=flush_id_ex=1, stall_pc=0, flush_events=1.
REQ-039 The bench SHALL check timeout: TIMEOUT=4 with no ack -> mem_err=1 after 4 WAIT cycles, FSM in IDLE, stalls released.
REQ-040 The bench SHALL check reset in WAIT: rst pulsed mid-WAIT -> dmem_req=0 asynchronously, the FSM in IDLE, and counters at 0.
